// File: rtl/bus_dma_copy.sv
// Word-granular memory-to-memory copy engine.
// It is a bus host for the copy traffic and a bus device for its own register window.
module bus_dma_copy #(
   parameter int AddressWidth = 32,
   parameter int DataWidth    = 32,
   parameter int LenWidth     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    dev_req_i,
   input  logic                    dev_we_i,
   input  logic [3:0]              dev_be_i,
   input  logic [AddressWidth-1:0] dev_addr_i,
   input  logic [DataWidth-1:0]    dev_wdata_i,
   output logic                    dev_rvalid_o,
   output logic [DataWidth-1:0]    dev_rdata_o,
   output logic                    dev_err_o,
   output logic                    host_req_o,
   input  logic                    host_gnt_i,
   output logic [AddressWidth-1:0] host_addr_o,
   output logic                    host_we_o,
   output logic [3:0]              host_be_o,
   output logic [DataWidth-1:0]    host_wdata_o,
   input  logic                    host_rvalid_i,
   input  logic [DataWidth-1:0]    host_rdata_i,
   input  logic                    host_err_i,
   output logic                    irq_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_RESP = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_RESP = 3'd4
   } state_e;

   state_e                  state_r, state_n;
   logic [AddressWidth-1:0] src_r, dst_r, cur_src_r, cur_src_n, cur_dst_r, cur_dst_n;
   logic [LenWidth-1:0]     len_r, remain_r, remain_n;
   logic [DataWidth-1:0]    buf_r, buf_n;
   logic                    ie_r, ie_n, done_r, done_n, err_r, err_n;
   logic                    host_req_r, host_req_n, host_we_r, host_we_n, irq_r;
   logic [AddressWidth-1:0] host_addr_r, host_addr_n;
   logic [DataWidth-1:0]    host_wdata_r, host_wdata_n;
   logic                    dev_rvalid_r, dev_err_r;
   logic [DataWidth-1:0]    dev_rdata_r, rd_data_s;
   logic                    rd_err_s;
   logic [2:0]              sel_s;
   logic                    wr_en_s, busy_s, start_s, w1c_s, ctrl_wr_s;
   logic                    unused_addr_s;

   assign sel_s         = dev_addr_i[4:2];
   assign unused_addr_s = ^{dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};
   assign wr_en_s       = dev_req_i && dev_we_i && (dev_be_i == 4'hF);
   assign busy_s        = (state_r != ST_IDLE);
   assign ctrl_wr_s     = wr_en_s && (sel_s == 3'd3);
   assign start_s       = ctrl_wr_s && dev_wdata_i[0] && !busy_s;
   assign w1c_s         = wr_en_s && (sel_s == 3'd4);
   assign ie_n          = ctrl_wr_s ? dev_wdata_i[1] : ie_r;

   // Software-visible configuration; the copy parameters are frozen while a transfer runs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_r <= '0;
         dst_r <= '0;
         len_r <= '0;
         ie_r  <= 1'b0;
      end else begin
         if (wr_en_s && !busy_s) begin
            case (sel_s)
               3'd0:    src_r <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
               3'd1:    dst_r <= {dev_wdata_i[AddressWidth-1:2], 2'b00};
               3'd2:    len_r <= dev_wdata_i[LenWidth-1:0];
               default: ;
            endcase
         end
         ie_r <= ie_n;
      end
   end

   // Copy sequencing; register W1C clears are applied first so hardware sets win
   always_comb begin
      state_n   = state_r;
      cur_src_n = cur_src_r;
      cur_dst_n = cur_dst_r;
      remain_n  = remain_r;
      buf_n     = buf_r;
      if (w1c_s) begin
         done_n = done_r & ~dev_wdata_i[1];
         err_n  = err_r & ~dev_wdata_i[2];
      end else begin
         done_n = done_r;
         err_n  = err_r;
      end
      case (state_r)
         ST_IDLE: begin
            if (start_s && (len_r == '0)) begin
               done_n = 1'b1;
            end else if (start_s) begin
               cur_src_n = src_r;
               cur_dst_n = dst_r;
               remain_n  = len_r;
               done_n    = 1'b0;
               err_n     = 1'b0;
               state_n   = ST_RD_REQ;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            if (host_gnt_i) state_n = ST_RD_RESP;
            else            state_n = ST_RD_REQ;
         end
         ST_RD_RESP: begin
            if (host_rvalid_i && host_err_i) begin
               err_n   = 1'b1;
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end else if (host_rvalid_i) begin
               buf_n   = host_rdata_i;
               state_n = ST_WR_REQ;
            end else begin
               state_n = ST_RD_RESP;
            end
         end
         ST_WR_REQ: begin
            if (host_gnt_i) state_n = ST_WR_RESP;
            else            state_n = ST_WR_REQ;
         end
         ST_WR_RESP: begin
            if (host_rvalid_i && host_err_i) begin
               err_n   = 1'b1;
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end else if (host_rvalid_i) begin
               cur_src_n = cur_src_r + AddressWidth'(3'd4);
               cur_dst_n = cur_dst_r + AddressWidth'(3'd4);
               remain_n  = remain_r - LenWidth'(1'b1);
               if (remain_r == LenWidth'(1'b1)) begin
                  done_n  = 1'b1;
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_RD_REQ;
               end
            end else begin
               state_n = ST_WR_RESP;
            end
         end
         default: state_n = ST_IDLE;
      endcase
      // Host outputs are registered from the next state so they are glitch-free and held
      host_req_n = (state_n == ST_RD_REQ) || (state_n == ST_WR_REQ);
      host_we_n  = (state_n == ST_WR_REQ);
      if (state_n == ST_RD_REQ) begin
         host_addr_n  = cur_src_n;
         host_wdata_n = host_wdata_r;
      end else if (state_n == ST_WR_REQ) begin
         host_addr_n  = cur_dst_n;
         host_wdata_n = buf_n;
      end else begin
         host_addr_n  = host_addr_r;
         host_wdata_n = host_wdata_r;
      end
   end

   // State, datapath and registered host-side outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_IDLE;
         cur_src_r    <= '0;
         cur_dst_r    <= '0;
         remain_r     <= '0;
         buf_r        <= '0;
         done_r       <= 1'b0;
         err_r        <= 1'b0;
         host_req_r   <= 1'b0;
         host_we_r    <= 1'b0;
         host_addr_r  <= '0;
         host_wdata_r <= '0;
         irq_r        <= 1'b0;
      end else begin
         state_r      <= state_n;
         cur_src_r    <= cur_src_n;
         cur_dst_r    <= cur_dst_n;
         remain_r     <= remain_n;
         buf_r        <= buf_n;
         done_r       <= done_n;
         err_r        <= err_n;
         host_req_r   <= host_req_n;
         host_we_r    <= host_we_n;
         host_addr_r  <= host_addr_n;
         host_wdata_r <= host_wdata_n;
         irq_r        <= done_n & ie_n;
      end
   end

   // Register read mux; the two unused slots in the window answer with an error
   always_comb begin
      rd_data_s = '0;
      rd_err_s  = 1'b0;
      case (sel_s)
         3'd0:    rd_data_s = DataWidth'(src_r);
         3'd1:    rd_data_s = DataWidth'(dst_r);
         3'd2:    rd_data_s = DataWidth'(len_r);
         3'd3:    rd_data_s = DataWidth'({ie_r, 1'b0});
         3'd4:    rd_data_s = DataWidth'({err_r, done_r, busy_s});
         3'd5:    rd_data_s = DataWidth'(remain_r);
         default: rd_err_s  = 1'b1;
      endcase
   end

   // Device response one cycle after the request, with data sampled at request time
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dev_rvalid_r <= 1'b0;
         dev_err_r    <= 1'b0;
         dev_rdata_r  <= '0;
      end else begin
         dev_rvalid_r <= dev_req_i;
         dev_err_r    <= dev_req_i && rd_err_s;
         dev_rdata_r  <= (dev_req_i && !dev_we_i) ? rd_data_s : '0;
      end
   end

   assign dev_rvalid_o = dev_rvalid_r;
   assign dev_err_o    = dev_err_r;
   assign dev_rdata_o  = dev_rdata_r;
   assign host_req_o   = host_req_r;
   assign host_we_o    = host_we_r;
   assign host_addr_o  = host_addr_r;
   assign host_wdata_o = host_wdata_r;
   assign host_be_o    = 4'hF;
   assign irq_o        = irq_r;

endmodule

// File: tb/tb_bus_dma_copy.sv
// Self-checking bench for bus_dma_copy: a randomized bus responder plus a
// transaction-level model of what each copy must put on the bus.
module tb_bus_dma_copy;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        dev_req_i, dev_we_i;
   logic [3:0]  dev_be_i;
   logic [31:0] dev_addr_i, dev_wdata_i, dev_rdata_o;
   logic        dev_rvalid_o, dev_err_o;
   logic        host_req_o, host_gnt_i, host_we_o, host_rvalid_i, host_err_i, irq_o;
   logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
   logic [3:0]  host_be_o;

   int checks = 0;
   int failures = 0;
   int gnt_lo = 0, gnt_hi = 3, lat_lo = 0, lat_hi = 2;
   int err_rd_idx = 0;
   int rd_cnt = 0;
   bit hold_writes = 1'b0;
   logic [31:0] tr_addr[$];
   bit          tr_we[$];
   logic [31:0] tr_data[$];

   bus_dma_copy dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
      .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
      .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
      .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
      .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
      .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
      .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] pat(logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Bus memory: random grant delay and response latency, content given by pat()
   initial begin : responder
      logic [31:0] a, d;
      logic        w;
      int          gd, lt;
      host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = 32'h0;
      forever begin
         @(negedge clk_i);
         host_rvalid_i = 1'b0; host_err_i = 1'b0; host_rdata_i = 32'h0;
         if (rst_ni && host_req_o && !(hold_writes && host_we_o)) begin
            a = host_addr_o; w = host_we_o; d = host_wdata_o;
            check("host_be", 32'(host_be_o), 32'hF);
            gd = $urandom_range(gnt_hi, gnt_lo);
            repeat (gd) begin
               @(negedge clk_i);
               check("req_held", 32'(host_req_o), 32'h1);
               check("addr_held", host_addr_o, a);
               check("we_held", 32'(host_we_o), 32'(w));
               if (w) check("wdata_held", host_wdata_o, d);
            end
            host_gnt_i = 1'b1;
            @(negedge clk_i);
            host_gnt_i = 1'b0;
            lt = $urandom_range(lat_hi, lat_lo);
            for (int k = 0; k <= lt; k++) begin
               if (k > 0) @(negedge clk_i);
               check("one_outstanding", 32'(host_req_o), 32'h0);
            end
            host_rvalid_i = 1'b1;
            if (!w) begin
               rd_cnt++;
               host_rdata_i = pat(a);
               host_err_i   = (rd_cnt == err_rd_idx);
            end
            tr_addr.push_back(a); tr_we.push_back(w); tr_data.push_back(w ? d : pat(a));
         end
      end
   end

   task automatic reg_write(logic [4:0] off, logic [31:0] data, logic exp_err);
      dev_req_i = 1'b1; dev_we_i = 1'b1; dev_be_i = 4'hF;
      dev_addr_i = {27'h0, off}; dev_wdata_i = data;
      @(negedge clk_i);
      dev_req_i = 1'b0; dev_we_i = 1'b0;
      check("wr_rvalid", 32'(dev_rvalid_o), 32'h1);
      check("wr_err", 32'(dev_err_o), 32'(exp_err));
   endtask

   task automatic reg_read(logic [4:0] off, output logic [31:0] data, output logic err);
      dev_req_i = 1'b1; dev_we_i = 1'b0; dev_be_i = 4'hF; dev_addr_i = {27'h0, off};
      @(negedge clk_i);
      dev_req_i = 1'b0;
      check("rd_rvalid", 32'(dev_rvalid_o), 32'h1);
      data = dev_rdata_o; err = dev_err_o;
   endtask

   task automatic expect_reg(string tag, logic [4:0] off, logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      reg_read(off, d, e);
      check(tag, d, exp);
      check("rd_err", 32'(e), 32'h0);
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      logic        e;
      int          n;
      n = 0;
      do begin
         reg_read(5'h10, s, e);
         n++;
      end while (s[0] && n < 2000);
      check("idle_timeout", 32'(s[0]), 32'h0);
   endtask

   task automatic start_copy(logic [31:0] src, logic [31:0] dst, logic [31:0] len, logic ie);
      tr_addr.delete(); tr_we.delete(); tr_data.delete(); rd_cnt = 0;
      reg_write(5'h00, src, 1'b0);
      reg_write(5'h04, dst, 1'b0);
      reg_write(5'h08, len, 1'b0);
      reg_write(5'h0C, {30'h0, ie, 1'b1}, 1'b0);
   endtask

   // Reference: reads and writes alternate R,W,R,W... word i reads src+4i and writes pat(src+4i) to dst+4i
   task automatic check_log(logic [31:0] src, logic [31:0] dst, int n_rd, int n_wr);
      int          n;
      logic [31:0] off;
      n = n_rd + n_wr;
      check("log_size", 32'(tr_addr.size()), 32'(n));
      for (int i = 0; i < n && i < tr_addr.size(); i++) begin
         off = 32'(4 * (i / 2));
         check("log_we", 32'(tr_we[i]), 32'(i % 2));
         check("log_addr", tr_addr[i], ((i % 2) == 1) ? dst + off : src + off);
         check("log_data", tr_data[i], pat(src + off));
      end
   endtask

   initial begin
      logic [31:0] d, src, dst;
      logic        e;
      int          len, k;
      dev_req_i = 1'b0; dev_we_i = 1'b0; dev_be_i = 4'h0; dev_addr_i = 32'h0; dev_wdata_i = 32'h0;
      repeat (3) @(negedge clk_i);
      check("rst_req", 32'(host_req_o), 32'h0);
      check("rst_we", 32'(host_we_o), 32'h0);
      check("rst_addr", host_addr_o, 32'h0);
      check("rst_wdata", host_wdata_o, 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      check("rst_dev_rvalid", 32'(dev_rvalid_o), 32'h0);
      check("rst_dev_err", 32'(dev_err_o), 32'h0);
      check("rst_dev_rdata", dev_rdata_o, 32'h0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      for (int r = 0; r < 6; r++) expect_reg("reset_reg", 5'(r * 4), 32'h0);

      // Basic copy with interrupt enabled
      start_copy(32'h0010_0000, 32'h0010_0400, 32'd4, 1'b1);
      wait_idle();
      check_log(32'h0010_0000, 32'h0010_0400, 4, 4);
      expect_reg("status_done", 5'h10, 32'h2);
      expect_reg("remain_zero", 5'h14, 32'h0);
      check("irq_set", 32'(irq_o), 32'h1);
      reg_write(5'h10, 32'h2, 1'b0);
      check("irq_clr", 32'(irq_o), 32'h0);
      expect_reg("status_clr", 5'h10, 32'h0);

      // Slow grant: responder checks the request stays stable for 5 cycles
      gnt_lo = 5; gnt_hi = 5;
      start_copy(32'h0020_0000, 32'h0020_0800, 32'd3, 1'b0);
      wait_idle();
      check_log(32'h0020_0000, 32'h0020_0800, 3, 3);
      check("irq_ie0", 32'(irq_o), 32'h0);
      gnt_lo = 0; gnt_hi = 3;
      reg_write(5'h10, 32'h6, 1'b0);

      // Zero-length start completes immediately without bus traffic
      start_copy(32'h0030_0000, 32'h0030_0400, 32'd0, 1'b0);
      expect_reg("len0_status", 5'h10, 32'h2);
      repeat (10) @(negedge clk_i);
      check("len0_no_bus", 32'(tr_addr.size()), 32'h0);
      reg_write(5'h10, 32'h2, 1'b0);

      // Read error on the second word
      err_rd_idx = 2;
      start_copy(32'h0030_0000, 32'h0030_0400, 32'd3, 1'b1);
      wait_idle();
      err_rd_idx = 0;
      expect_reg("err_status", 5'h10, 32'h6);
      expect_reg("err_remain", 5'h14, 32'h2);
      check_log(32'h0030_0000, 32'h0030_0400, 2, 1);
      check("err_irq", 32'(irq_o), 32'h1);
      reg_write(5'h10, 32'h6, 1'b0);
      expect_reg("err_clr", 5'h10, 32'h0);

      // Writes to SRC and a second start while busy are ignored
      gnt_lo = 2; gnt_hi = 4;
      start_copy(32'h0040_0000, 32'h0040_0400, 32'd4, 1'b0);
      reg_write(5'h00, 32'h0, 1'b0);
      reg_write(5'h0C, 32'h1, 1'b0);
      expect_reg("busy_src_kept", 5'h00, 32'h0040_0000);
      wait_idle();
      check_log(32'h0040_0000, 32'h0040_0400, 4, 4);
      expect_reg("busy_remain", 5'h14, 32'h0);
      gnt_lo = 0; gnt_hi = 3;
      reg_write(5'h00, 32'h0010_0003, 1'b0);
      expect_reg("src_align", 5'h00, 32'h0010_0000);
      dev_req_i = 1'b1; dev_we_i = 1'b1; dev_be_i = 4'h3; dev_addr_i = 32'h0; dev_wdata_i = 32'h0000_1234;
      @(negedge clk_i);
      dev_req_i = 1'b0; dev_we_i = 1'b0;
      expect_reg("partial_be_ignored", 5'h00, 32'h0010_0000);
      reg_write(5'h10, 32'h6, 1'b0);

      // Random copies, the first one wrapping the source address through zero
      for (int t = 0; t < 4; t++) begin
         src = (t == 0) ? 32'hFFFF_FFF8 : (($urandom & 32'h0FFF_FFFC) | 32'h1000_0000);
         dst = ($urandom & 32'h0FFF_FFFC) | 32'h2000_0000;
         len = $urandom_range(6, 1);
         start_copy(src, dst, 32'(len), 1'b0);
         wait_idle();
         check_log(src, dst, len, len);
         expect_reg("rand_status", 5'h10, 32'h2);
         expect_reg("rand_remain", 5'h14, 32'h0);
         reg_write(5'h10, 32'h2, 1'b0);
      end

      // Unmapped offsets
      reg_read(5'h18, d, e);
      check("bad_rdata", d, 32'h0);
      check("bad_err", 32'(e), 32'h1);
      reg_write(5'h1C, 32'hFFFF_FFFF, 1'b1);
      expect_reg("bad_wr_noeffect", 5'h10, 32'h0);

      // Reset while a write request is pending
      hold_writes = 1'b1;
      start_copy(32'h0050_0000, 32'h0050_0400, 32'd2, 1'b1);
      k = 0;
      while (!(host_req_o && host_we_o) && k < 200) begin
         @(negedge clk_i);
         k++;
      end
      check("wr_req_reached", 32'(host_req_o && host_we_o), 32'h1);
      #2 rst_ni = 1'b0;
      #1 check("rst_req_async", 32'(host_req_o), 32'h0);
      hold_writes = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      for (int r = 0; r < 6; r++) expect_reg("post_rst_reg", 5'(r * 4), 32'h0);
      repeat (5) @(negedge clk_i);
      check("post_rst_idle", 32'(host_req_o), 32'h0);
      check("post_rst_irq", 32'(irq_o), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
